dff_bank: RTL and testbench
===========================

# dff_bank

Parametrised register bank that generalises the single-bit set/reset flip-flop to a WIDTH-bit word. Each bit has its own set and clear, and one `sync` input chooses whether they act synchronously or asynchronously. The word also supports hold, parallel load and serial shift in either direction. It is the team's general-purpose state/shift register for lab datapaths and control words.

## Interface
- `WIDTH`, 8: word width, 2 or more.
- `RESET_VAL`, {WIDTH{1'b0}}: value of `q` while `r` is low.
- `clk`  in  1  rising-edge clock.
- `r`  in  1  asynchronous active-low reset.
- `sync`  in  1  1: `s`/`c` sampled on `clk`; 0: `s`/`c` act immediately (asynchronous).
- `s`  in  WIDTH  per-bit set, active-high.
- `c`  in  WIDTH  per-bit clear, active-high.
- `mode`  in  2  00 hold, 01 load `d`, 10 shift left, 11 shift right.
- `d`  in  WIDTH  parallel load data.
- `si`  in  1  serial input for shifts.
- `q`  out  WIDTH  register contents.
- `so`  out  1  registered bit shifted out on the last edge.
- `chg`  out  1  registered; 1 for one cycle after an edge whose clocked update changed `q`.

## Operation
- Priority per bit, highest first: `r` low > `c[i]` > `s[i]` > `mode`.
- `r` low: `q`=RESET_VAL, `so`=0, `chg`=0 immediately, regardless of `clk`. Release takes effect at the first rising edge after `r` goes high.
- Async path (`sync`=0):
  - `c[i]`=1 forces `q[i]`=0 without waiting for a clock edge.
  - Otherwise `s[i]`=1 forces `q[i]`=1.
  - The bit holds that value while asserted.
  - After deassertion, the bit keeps the forced value until the next clocked update.
- Sync path (`sync`=1): at the edge, `c[i]` gives next `q[i]`=0, else `s[i]` gives next `q[i]`=1, else the mode result applies.
- Mode result (`n`), computed from the `q` present at the edge:
  - 00: `n`=`q`.
  - 01: `n`=`d`.
  - 10: `n`={`q`[W-2:0], `si`}.
  - 11: `n`={`si`, `q`[W-1:1]}.
  - Set/clear overrides `n` per bit only. Other bits still shift or load.
- `so` at each edge:
  - mode 10: `so`=`q`[W-1] (pre-edge value).
  - mode 11: `so`=`q`[0].
  - otherwise `so`=0.
- `chg` at each edge = |(next `q` ^ pre-edge `q`). Asynchronous set/clear effects never raise `chg`.
- Both `s[i]` and `c[i]` set: clear wins, in both sync and async modes.
- Toggling `sync` while `s`/`c` are asserted:
  - 1→0: the override becomes immediate.
  - 0→1: the bits keep their forced value until the next edge applies the sync rule.

## Timing
- Clocked updates take effect one edge after inputs are sampled (setup relative to rising `clk`).
- Async set/clear and reset: combinational-path-to-flop only; no clock needed. `q` reflects them within the same cycle.
- `so` and `chg` are valid from the edge that produced them and hold for exactly one cycle unless re-driven.
- No multi-cycle operations; throughput is one operation per clock.
- Reset mid-shift: contents are lost. The first edge after release operates on RESET_VAL.

## Test plan
- Reset and load: `r`=0 with `d`=8'hA5 and `mode`=01 → `q`=00, `so`=0, `chg`=0. Release `r`, one edge → `q`=A5, `chg`=1. Next edge with `mode`=00 → `q`=A5, `chg`=0.
- Shift both ways: `q`=8'h81, `mode`=10, `si`=0, one edge → `q`=02, `so`=1. Then `mode`=11, `si`=1 → `q`=81, `so`=0.
- Sync set/clear: `sync`=1, `q`=00, `s`=8'h0F, `c`=8'h03, `mode`=00 → no change before the edge. After the edge `q`=0C, `chg`=1. Set and clear on the same bits: clear wins.
- Async set/clear: `sync`=0, `clk` stopped, `s`=8'hF0 → `q`=F0 immediately, `chg` stays 0. Deassert `s` → `q` stays F0. Assert `c`=8'h80 → `q`=70.
- Override during shift: `sync`=1, `q`=00, `mode`=10, `si`=1, `s`=8'h80, three edges → `q`=01, 03, 07 with bit 7 set on each (81, 83, 87).
- Async reset mid-operation: `mode`=10 streaming `si`=1. Pull `r` low between edges → `q`=RESET_VAL at once. Release `r`, one edge → `q`=01, `so`=0.

Source files
------------

// File: rtl/dff_bank.sv
// WIDTH-bit register bank: per-bit set/clear (sync or async via `sync`), hold,
// parallel load and bidirectional serial shift, with registered shift-out and change flag.
module dff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             sync,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             chg
);

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] held;
    logic             so_d;
    logic             chg_d;

    always_comb begin
        n     = q;
        so_d  = 1'b0;
        case (mode)
            2'b01: n = d;
            2'b10: begin
                n    = {q[WIDTH-2:0], si};
                so_d = q[WIDTH-1];
            end
            2'b11: begin
                n    = {si, q[WIDTH-1:1]};
                so_d = q[0];
            end
            default: n = q;
        endcase

        // Bits under an async override ignore the clock, so they cannot contribute to chg.
        if (sync) begin
            nxt  = (n | s) & ~c;
            held = '0;
        end else begin
            nxt  = n;
            held = s | c;
        end
        chg_d = |((nxt ^ q) & ~held);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic clr_n;
        logic set_n;
        logic q_bit;

        // Reset maps onto the preset or clear pin depending on this bit's RESET_VAL.
        assign clr_n = ~((~r & ~RESET_VAL[i]) | (r & ~sync & c[i]));
        assign set_n = ~((~r &  RESET_VAL[i]) | (r & ~sync & s[i] & ~c[i]));

        always_ff @(posedge clk or negedge clr_n or negedge set_n) begin
            if (!clr_n) begin
                q_bit <= 1'b0;
            end else if (!set_n) begin
                q_bit <= 1'b1;
            end else begin
                q_bit <= nxt[i];
            end
        end

        assign q[i] = q_bit;
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            so  <= 1'b0;
            chg <= 1'b0;
        end else begin
            so  <= so_d;
            chg <= chg_d;
        end
    end

endmodule

// File: tb/tb_dff_bank.sv
// Self-checking bench for dff_bank: directed scenarios plus randomized traffic
// compared against a per-bit priority model of the register bank.
module tb_dff_bank;

    localparam int       W  = 8;
    localparam [W-1:0]   RV = 8'h00;

    logic         clk = 1'b0;
    logic         r = 1'b1;
    logic         sync = 1'b1;
    logic [W-1:0] s = '0;
    logic [W-1:0] c = '0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] d = '0;
    logic         si = 1'b0;
    logic [W-1:0] q;
    logic         so;
    logic         chg;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] m_q = RV;
    logic         m_so = 1'b0;
    logic         m_chg = 1'b0;

    dff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .r(r), .sync(sync), .s(s), .c(c), .mode(mode),
        .d(d), .si(si), .q(q), .so(so), .chg(chg)
    );

    always #5 clk = ~clk;

    // Level-sensitive effects: reset and async overrides act as soon as inputs change.
    task automatic model_async();
        if (!r) begin
            m_q   = RV;
            m_so  = 1'b0;
            m_chg = 1'b0;
        end else if (!sync) begin
            for (int i = 0; i < W; i++) begin
                if (c[i]) m_q[i] = 1'b0;
                else if (s[i]) m_q[i] = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] old_q;
        logic [W-1:0] res;
        logic [W-1:0] new_q;
        if (!r) begin
            m_q = RV; m_so = 1'b0; m_chg = 1'b0;
        end else begin
            old_q = m_q;
            m_so  = 1'b0;
            if (mode == 2'b01) res = d;
            else if (mode == 2'b10) begin
                res  = (old_q << 1) + W'(si);
                m_so = old_q[W-1];
            end else if (mode == 2'b11) begin
                res  = (old_q >> 1) + (W'(si) << (W - 1));
                m_so = old_q[0];
            end else res = old_q;
            for (int i = 0; i < W; i++) begin
                if (!sync && (c[i] || s[i])) new_q[i] = old_q[i];
                else if (sync && c[i]) new_q[i] = 1'b0;
                else if (sync && s[i]) new_q[i] = 1'b1;
                else new_q[i] = res[i];
            end
            m_chg = (new_q != old_q);
            m_q   = new_q;
        end
    endtask

    task automatic drive(input logic r_v, input logic sync_v, input logic [W-1:0] s_v,
                         input logic [W-1:0] c_v, input logic [1:0] mode_v,
                         input logic [W-1:0] d_v, input logic si_v);
        r = r_v; sync = sync_v; s = s_v; c = c_v; mode = mode_v; d = d_v; si = si_v;
        #1;
        model_async();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset_load();
        drive(1'b0, 1'b1, 8'h00, 8'h00, 2'b01, 8'hA5, 1'b0);
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if (so !== 1'b0) begin failures++; $display("FAIL reset_so got=%b exp=0", so); end
        checks++; if (chg !== 1'b0) begin failures++; $display("FAIL reset_chg got=%b exp=0", chg); end
        tick();
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_hold_q got=%h exp=00", q); end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b01, 8'hA5, 1'b0);
        tick();
        checks++; if (q !== 8'hA5) begin failures++; $display("FAIL load_q got=%h exp=a5", q); end
        checks++; if (chg !== 1'b1) begin failures++; $display("FAIL load_chg got=%b exp=1", chg); end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
        tick();
        checks++; if (q !== 8'hA5) begin failures++; $display("FAIL hold_q got=%h exp=a5", q); end
        checks++; if (chg !== 1'b0) begin failures++; $display("FAIL hold_chg got=%b exp=0", chg); end
    endtask

    task automatic test_shift();
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b01, 8'h81, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b10, 8'h00, 1'b0);
        tick();
        checks++; if (q !== 8'h02) begin failures++; $display("FAIL shl_q got=%h exp=02", q); end
        checks++; if (so !== 1'b1) begin failures++; $display("FAIL shl_so got=%b exp=1", so); end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b11, 8'h00, 1'b1);
        tick();
        checks++; if (q !== 8'h81) begin failures++; $display("FAIL shr_q got=%h exp=81", q); end
        checks++; if (so !== 1'b0) begin failures++; $display("FAIL shr_so got=%b exp=0", so); end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b11, 8'h00, 1'b0);
        tick();
        checks++; if (q !== 8'h40 || so !== 1'b1) begin failures++; $display("FAIL shr2 got q=%h so=%b exp q=40 so=1", q, so); end
    endtask

    task automatic test_sync_setclr();
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h0F, 8'h03, 2'b00, 8'h00, 1'b0);
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL sync_pre_edge got=%h exp=00", q); end
        tick();
        checks++; if (q !== 8'h0C) begin failures++; $display("FAIL sync_sc_q got=%h exp=0c", q); end
        checks++; if (chg !== 1'b1) begin failures++; $display("FAIL sync_sc_chg got=%b exp=1", chg); end
        drive(1'b1, 1'b1, 8'h30, 8'h34, 2'b00, 8'h00, 1'b0);
        tick();
        checks++; if (q !== 8'h08) begin failures++; $display("FAIL sync_clr_wins got=%h exp=08", q); end
    endtask

    task automatic test_async_setclr();
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 8'hF0, 8'h00, 2'b00, 8'h00, 1'b0);
        checks++; if (q !== 8'hF0) begin failures++; $display("FAIL async_set got=%h exp=f0", q); end
        checks++; if (chg !== 1'b0) begin failures++; $display("FAIL async_set_chg got=%b exp=0", chg); end
        drive(1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
        checks++; if (q !== 8'hF0) begin failures++; $display("FAIL async_keep got=%h exp=f0", q); end
        drive(1'b1, 1'b0, 8'h00, 8'h80, 2'b00, 8'h00, 1'b0);
        checks++; if (q !== 8'h70) begin failures++; $display("FAIL async_clr got=%h exp=70", q); end
        drive(1'b1, 1'b0, 8'h81, 8'h81, 2'b00, 8'h00, 1'b0);
        checks++; if (q !== 8'h70) begin failures++; $display("FAIL async_clr_wins got=%h exp=70", q); end
        tick();
        checks++; if (q !== 8'h70 || chg !== 1'b0) begin failures++; $display("FAIL async_held_edge got q=%h chg=%b exp q=70 chg=0", q, chg); end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    endtask

    task automatic test_override_shift();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 8'h81; exp_seq[1] = 8'h83; exp_seq[2] = 8'h87;
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h80, 8'h00, 2'b10, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (q !== exp_seq[k]) begin failures++; $display("FAIL override_shift_%0d got=%h exp=%h", k, q, exp_seq[k]); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b10, 8'h00, 1'b1);
        tick();
        tick();
        drive(1'b0, 1'b1, 8'h00, 8'h00, 2'b10, 8'h00, 1'b1);
        checks++; if (q !== RV || so !== 1'b0 || chg !== 1'b0) begin failures++; $display("FAIL mid_reset got q=%h so=%b chg=%b exp q=%h so=0 chg=0", q, so, chg, RV); end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 2'b10, 8'h00, 1'b1);
        tick();
        checks++; if (q !== 8'h01 || so !== 1'b0) begin failures++; $display("FAIL mid_release got q=%h so=%b exp q=01 so=0", q, so); end
    endtask

    task automatic test_random();
        logic [W-1:0] rs, rc;
        for (int k = 0; k < 400; k++) begin
            rs = ($urandom_range(0, 2) == 0) ? W'($urandom) & W'($urandom) : '0;
            rc = ($urandom_range(0, 2) == 0) ? W'($urandom) & W'($urandom) : '0;
            drive(($urandom_range(0, 19) != 0), 1'($urandom), rs, rc,
                  2'($urandom), W'($urandom), 1'($urandom));
            checks++;
            if (q !== m_q || so !== m_so || chg !== m_chg) begin
                failures++;
                $display("FAIL rand_async_%0d got q=%h so=%b chg=%b exp q=%h so=%b chg=%b", k, q, so, chg, m_q, m_so, m_chg);
            end
            tick();
            checks++;
            if (q !== m_q || so !== m_so || chg !== m_chg) begin
                failures++;
                $display("FAIL rand_edge_%0d got q=%h so=%b chg=%b exp q=%h so=%b chg=%b", k, q, so, chg, m_q, m_so, m_chg);
            end
        end
    endtask

    initial begin
        test_reset_load();
        test_shift();
        test_sync_setclr();
        test_async_setclr();
        test_override_shift();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
